// File: rtl/bm_pkg.sv
// Shared Box-Muller operand widths and the uniform-word to operand repacking rule.
// Imported by the sample formatter and the downstream log/sqrt and sin/cos stages.
package bm_pkg;

  localparam int unsigned URNG_W = 32;
  localparam int unsigned U0_W   = 48;
  localparam int unsigned U1_W   = 16;

  localparam logic [U0_W-1:0] U0_ZERO_SUB = 48'h1;

  typedef struct packed {
    logic [U0_W-1:0] u0;
    logic [U1_W-1:0] u1;
  } bm_sample_t;

  // u0 feeds ln(), so an all-zero operand is replaced by the smallest nonzero value.
  function automatic bm_sample_t bm_format(input logic [URNG_W-1:0] a,
                                           input logic [URNG_W-1:0] b);
    bm_sample_t s;
    s.u0 = {a, b[URNG_W-1:U1_W]};
    s.u1 = b[U1_W-1:0];
    if (s.u0 == '0) begin
      s.u0 = U0_ZERO_SUB;
    end
    return s;
  endfunction

endpackage

// File: rtl/bm_sample_fifo.sv
// First-word-fall-through FIFO of Box-Muller samples with occupancy output.
// A push into a full FIFO is accepted only when a pop frees the head in the same cycle.
module bm_sample_fifo
  import bm_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   push_i,
  input  bm_sample_t             data_i,
  input  logic                   pop_i,
  output bm_sample_t             data_o,
  output logic [$clog2(DEPTH):0] level_o,
  output logic                   full_o,
  output logic                   empty_o
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [AW-1:0] wptr_q, wptr_d;
  logic [AW-1:0] rptr_q, rptr_d;
  logic [AW:0]   level_q, level_d;
  logic          do_push, do_pop;

  bm_sample_t mem_q [DEPTH];

  assign full_o  = (level_q == (AW+1)'(DEPTH));
  assign empty_o = (level_q == '0);
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);
  assign level_o = level_q;
  assign data_o  = empty_o ? '0 : mem_q[rptr_q];

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    level_d = level_q;
    if (do_push) begin
      wptr_d = wptr_q + 1'b1;
    end
    if (do_pop) begin
      rptr_d = rptr_q + 1'b1;
    end
    unique case ({do_push, do_pop})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      level_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      level_q <= level_d;
    end
  end

  // Storage is not reset; data_o is masked to zero while empty.
  always_ff @(posedge clk_i) begin
    if (do_push) begin
      mem_q[wptr_q] <= data_i;
    end
  end

endmodule

// File: rtl/urng_sample_formatter.sv
// Captures the dual-Tausworthe uniform words, skips the warm-up run, repacks them into
// Box-Muller operands and buffers them; samples arriving at a full FIFO are dropped.
module urng_sample_formatter
  import bm_pkg::*;
#(
  parameter int unsigned WARMUP = 8,
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned DROP_W = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   enable,
  input  logic [URNG_W-1:0]      a,
  input  logic [URNG_W-1:0]      b,
  input  logic                   out_ready,
  output logic [U0_W-1:0]        u0,
  output logic [U1_W-1:0]        u1,
  output logic                   out_valid,
  output logic                   warm,
  output logic [DROP_W-1:0]      drop_count,
  output logic [$clog2(DEPTH):0] fifo_level
);

  localparam int unsigned WC_W = (WARMUP == 0) ? 1 : $clog2(WARMUP + 1);

  logic [URNG_W-1:0] s1_a_q, s1_a_d;
  logic [URNG_W-1:0] s1_b_q, s1_b_d;
  logic              s1_v_q, s1_v_d;
  bm_sample_t        s2_q, s2_d;
  logic              s2_v_q, s2_v_d;
  logic [WC_W-1:0]   wcnt_q, wcnt_d;
  logic              warm_q, warm_d;
  logic [DROP_W-1:0] drop_q, drop_d;

  bm_sample_t head;
  logic       fifo_full, fifo_empty, pop, drop;

  assign pop  = ~fifo_empty & out_ready;
  assign drop = s2_v_q & fifo_full & ~pop;

  always_comb begin
    s1_a_d = a;
    s1_b_d = b;
    s1_v_d = enable;

    s2_d   = bm_format(s1_a_q, s1_b_q);
    s2_v_d = s1_v_q & warm_q;

    // Each valid sample seen while cold is discarded; the last discard raises warm.
    wcnt_d = wcnt_q;
    warm_d = warm_q;
    if (WARMUP == 0) begin
      warm_d = 1'b1;
    end else if (s1_v_q && !warm_q) begin
      wcnt_d = wcnt_q + 1'b1;
      if (wcnt_q == WC_W'(WARMUP - 1)) begin
        warm_d = 1'b1;
      end
    end

    drop_d = drop_q;
    if (drop && (drop_q != '1)) begin
      drop_d = drop_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1_a_q <= '0;
      s1_b_q <= '0;
      s1_v_q <= 1'b0;
      s2_q   <= '0;
      s2_v_q <= 1'b0;
      wcnt_q <= '0;
      warm_q <= 1'b0;
      drop_q <= '0;
    end else begin
      s1_a_q <= s1_a_d;
      s1_b_q <= s1_b_d;
      s1_v_q <= s1_v_d;
      s2_q   <= s2_d;
      s2_v_q <= s2_v_d;
      wcnt_q <= wcnt_d;
      warm_q <= warm_d;
      drop_q <= drop_d;
    end
  end

  bm_sample_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i   (clk),
    .rst_ni  (reset),
    .push_i  (s2_v_q),
    .data_i  (s2_q),
    .pop_i   (pop),
    .data_o  (head),
    .level_o (fifo_level),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign u0         = head.u0;
  assign u1         = head.u1;
  assign out_valid  = ~fifo_empty;
  assign warm       = warm_q;
  assign drop_count = drop_q;

endmodule

// File: tb/tb_urng_sample_formatter.sv
// Randomized and directed bench for urng_sample_formatter against a queue-based
// behavioural model of capture, warm-up, formatting and the dropping FIFO.
module tb_urng_sample_formatter;

  localparam int WARMUP = 8;
  localparam int DEPTH  = 4;
  localparam int DROP_W = 16;
  localparam int DROP_MAX = (1 << DROP_W) - 1;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        enable = 1'b0;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        out_ready = 1'b0;
  logic [47:0] u0;
  logic [15:0] u1;
  logic        out_valid;
  logic        warm;
  logic [DROP_W-1:0] drop_count;
  logic [$clog2(DEPTH):0] fifo_level;

  urng_sample_formatter #(
    .WARMUP (WARMUP),
    .DEPTH  (DEPTH),
    .DROP_W (DROP_W)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .a          (a),
    .b          (b),
    .out_ready  (out_ready),
    .u0         (u0),
    .u1         (u1),
    .out_valid  (out_valid),
    .warm       (warm),
    .drop_count (drop_count),
    .fifo_level (fifo_level)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Behavioural model: a pipeline of two captured words, a sample queue, plain counters.
  bit          m_s1_v, m_s2_v, m_warm;
  logic [31:0] m_s1_a, m_s1_b;
  logic [63:0] m_s2;
  int          m_seen, m_drop;
  logic [63:0] m_q[$];

  function automatic logic [63:0] fmt(input logic [31:0] fa, input logic [31:0] fb);
    logic [63:0] v;
    logic [47:0] w0;
    v  = {fa, fb};
    w0 = v[63:16];
    if (w0 == 48'd0) w0 = 48'd1;
    return {w0, v[15:0]};
  endfunction

  task automatic model_clear();
    m_s1_v = 0; m_s2_v = 0; m_warm = 0;
    m_s1_a = '0; m_s1_b = '0; m_s2 = '0;
    m_seen = 0; m_drop = 0;
    m_q.delete();
  endtask

  task automatic model_step();
    bit pop;
    int sz;
    pop = (m_q.size() > 0) && out_ready;
    sz  = m_q.size();
    if (m_s2_v) begin
      if (sz < DEPTH || pop) m_q.push_back(m_s2);
      else if (m_drop < DROP_MAX) m_drop++;
    end
    if (pop) void'(m_q.pop_front());
    m_s2_v = m_s1_v && m_warm;
    m_s2   = fmt(m_s1_a, m_s1_b);
    if (WARMUP == 0) m_warm = 1;
    else if (m_s1_v && !m_warm) begin
      m_seen++;
      if (m_seen >= WARMUP) m_warm = 1;
    end
    m_s1_v = enable; m_s1_a = a; m_s1_b = b;
  endtask

  always @(posedge clk or negedge reset) begin
    if (!reset) model_clear();
    else model_step();
  end

  task automatic check_all();
    logic [63:0] head;
    head = (m_q.size() > 0) ? m_q[0] : 64'd0;
    check_val("out_valid", 64'(out_valid), 64'(m_q.size() != 0));
    check_val("u0", 64'(u0), 64'(head[63:16]));
    check_val("u1", 64'(u1), 64'(head[15:0]));
    check_val("warm", 64'(warm), 64'(m_warm));
    check_val("fifo_level", 64'(fifo_level), 64'(m_q.size()));
    check_val("drop_count", 64'(drop_count), 64'(m_drop));
  endtask

  // Called at a falling edge: drive inputs, let one rising edge pass, check at next fall.
  task automatic cyc(input bit en, input logic [31:0] aa, input logic [31:0] bb,
                     input bit rdy);
    enable = en; a = aa; b = bb; out_ready = rdy;
    @(negedge clk);
    check_all();
  endtask

  logic [63:0] bp_exp[4];
  logic [31:0] ra, rb;
  bit          got_first;

  initial begin
    model_clear();
    repeat (2) @(negedge clk);
    check_all();
    check_val("rst_level", 64'(fifo_level), 64'd0);
    reset = 1'b1;

    // Warm-up: counting stream, first output is the ninth sample.
    got_first = 0;
    for (int i = 1; i <= 14; i++) begin
      cyc(1'b1, 32'(i), 32'(i) << 16, 1'b1);
      if (out_valid && !got_first) begin
        got_first = 1;
        check_val("first_u0", 64'(u0), 64'h0000_0009_0009);
        check_val("first_u1", 64'(u1), 64'h0);
      end
    end
    check_val("first_seen", 64'(got_first), 64'd1);
    repeat (4) cyc(1'b0, '0, '0, 1'b1);

    // Formatting and zero guard, held at the head with out_ready low.
    cyc(1'b1, 32'hDEADBEEF, 32'h12345678, 1'b0);
    repeat (2) cyc(1'b0, '0, '0, 1'b0);
    check_val("fmt_u0", 64'(u0), 64'hDEAD_BEEF_1234);
    check_val("fmt_u1", 64'(u1), 64'h5678);
    cyc(1'b0, '0, '0, 1'b1);
    cyc(1'b1, 32'h0, 32'h0000ABCD, 1'b0);
    repeat (2) cyc(1'b0, '0, '0, 1'b0);
    check_val("zero_u0", 64'(u0), 64'h1);
    check_val("zero_u1", 64'(u1), 64'hABCD);
    cyc(1'b0, '0, '0, 1'b1);

    // Back-pressure: ten samples into a stalled four-entry FIFO.
    for (int i = 0; i < 10; i++) begin
      ra = $urandom; rb = $urandom;
      if (i < 4) bp_exp[i] = fmt(ra, rb);
      cyc(1'b1, ra, rb, 1'b0);
    end
    repeat (2) cyc(1'b0, '0, '0, 1'b0);
    check_val("bp_level", 64'(fifo_level), 64'd4);
    check_val("bp_drop", 64'(drop_count), 64'd6);
    for (int j = 0; j < 4; j++) begin
      check_val("bp_order", {u0, u1}, bp_exp[j]);
      cyc(1'b0, '0, '0, 1'b1);
    end

    // Full with simultaneous push and pop.
    repeat (6) cyc(1'b1, $urandom, $urandom, 1'b0);
    for (int i = 0; i < 12; i++) begin
      cyc(1'b1, $urandom, $urandom, 1'b1);
      check_val("fullpp_level", 64'(fifo_level), 64'd4);
      check_val("fullpp_drop", 64'(drop_count), 64'd6);
    end
    repeat (8) cyc(1'b0, '0, '0, 1'b1);

    // Random traffic with an asynchronous reset pulse in the middle.
    for (int i = 0; i < 300; i++) begin
      if (i == 150) begin
        #2 reset = 1'b0;
        #1;
        check_val("arst_valid", 64'(out_valid), 64'd0);
        check_val("arst_warm", 64'(warm), 64'd0);
        check_val("arst_level", 64'(fifo_level), 64'd0);
        check_val("arst_drop", 64'(drop_count), 64'd0);
        @(negedge clk);
        repeat (2) cyc(1'b1, $urandom, $urandom, 1'b1);
        reset = 1'b1;
        cyc(1'b1, $urandom, $urandom, 1'b1);
        check_val("rewarm_low", 64'(warm), 64'd0);
        repeat (11) cyc(1'b1, $urandom, $urandom, 1'b1);
        check_val("rewarm_high", 64'(warm), 64'd1);
      end
      ra = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
      rb = ($urandom_range(0, 7) == 0) ? 32'(16'($urandom)) : $urandom;
      cyc(1'($urandom_range(0, 3) != 0), ra, rb, 1'($urandom_range(0, 2) != 0));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
